// File: rtl/star_center_switch_ctrl_pkg.sv
// Shared definitions for the star-topology centre router: port count,
// address widths, local port index and the per-output state encoding.
package star_center_switch_ctrl_pkg;

  localparam int DEF_NPORTS = 4;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_SEL_W  = 2;
  localparam int LOCAL_PORT = 0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } out_state_e;

endpackage

// File: rtl/star_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr,
// wrapping modulo N; returns a one-hot grant and its encoded index.
module star_rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx
);

  int   idx;
  logic found;

  // Scan from the pointer and take the first active request.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = W'(idx);
      end
    end
  end

endmodule

// File: rtl/star_center_switch_ctrl.sv
// Switch-allocation controller for the star centre router. Routes each
// input's head flit to an output, arbitrates round-robin per output and
// holds a wormhole lock until the tail flit transfers. Invalid targets
// are swallowed through a per-input drop flag.
//
// Per-output state table:
//   state     | meaning
//   ST_IDLE   | output free; arbitrates head requests each cycle
//   ST_LOCKED | output owned by owner_q[j] until its tail flit transfers
module star_center_switch_ctrl
  import star_center_switch_ctrl_pkg::*;
#(
  parameter int NPORTS = DEF_NPORTS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SEL_W  = DEF_SEL_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NPORTS-1:0]         in_valid,
  input  logic [NPORTS*ADDR_W-1:0]  in_src,
  input  logic [NPORTS*ADDR_W-1:0]  in_dest,
  input  logic [NPORTS-1:0]         in_tail,
  output logic [NPORTS-1:0]         in_ready,
  input  logic [NPORTS-1:0]         out_ready,
  output logic [NPORTS-1:0]         out_valid,
  output logic [NPORTS*SEL_W-1:0]   out_sel,
  output logic [NPORTS-1:0]         out_busy,
  output logic [NPORTS-1:0]         drop_err
);

  out_state_e state_q [NPORTS];
  out_state_e state_d [NPORTS];

  logic [NPORTS-1:0][SEL_W-1:0]  owner_q, owner_d;
  logic [NPORTS-1:0][SEL_W-1:0]  rr_q, rr_d;
  logic [NPORTS-1:0][SEL_W-1:0]  gnt_idx;
  logic [NPORTS-1:0][SEL_W-1:0]  sel_w;
  logic [NPORTS-1:0][NPORTS-1:0] req;
  logic [NPORTS-1:0][NPORTS-1:0] gnt;
  logic [NPORTS-1:0][ADDR_W-1:0] tgt;

  logic [NPORTS-1:0] tgt_ok;
  logic [NPORTS-1:0] locked_in;
  logic [NPORTS-1:0] head;
  logic [NPORTS-1:0] drop_head;
  logic [NPORTS-1:0] drop_q, drop_d;
  logic [NPORTS-1:0] ready_lk;

  // Route each input: same src/dest goes to the local port, else to dest.
  always_comb begin
    tgt    = '0;
    tgt_ok = '0;
    for (int i = 0; i < NPORTS; i++) begin
      tgt[i] = (in_src[i*ADDR_W +: ADDR_W] == in_dest[i*ADDR_W +: ADDR_W])
             ? ADDR_W'(LOCAL_PORT) : in_dest[i*ADDR_W +: ADDR_W];
      tgt_ok[i] = (int'(tgt[i]) < NPORTS);
    end
  end

  // An input is a head when no output owns it and it is not being dropped.
  always_comb begin
    locked_in = '0;
    for (int j = 0; j < NPORTS; j++) begin
      for (int i = 0; i < NPORTS; i++) begin
        if (state_q[j] == ST_LOCKED && owner_q[j] == SEL_W'(i)) begin
          locked_in[i] = 1'b1;
        end
      end
    end
    head      = ~locked_in & ~drop_q;
    drop_head = head & in_valid & ~tgt_ok;
  end

  // Build per-output request vectors from valid head flits.
  always_comb begin
    req = '0;
    for (int j = 0; j < NPORTS; j++) begin
      for (int i = 0; i < NPORTS; i++) begin
        req[j][i] = head[i] & in_valid[i] & tgt_ok[i] & (tgt[i] == ADDR_W'(j));
      end
    end
  end

  genvar gj;
  generate
    for (gj = 0; gj < NPORTS; gj++) begin : g_arb
      star_rr_arbiter #(
        .N (NPORTS),
        .W (SEL_W)
      ) u_arb (
        .req     (req[gj]),
        .ptr     (rr_q[gj]),
        .gnt     (gnt[gj]),
        .gnt_idx (gnt_idx[gj])
      );
    end
  endgenerate

  // Per-output next state, lock bookkeeping and flow-control outputs.
  always_comb begin
    owner_d   = owner_q;
    rr_d      = rr_q;
    out_valid = '0;
    out_busy  = '0;
    sel_w     = '0;
    ready_lk  = '0;
    for (int j = 0; j < NPORTS; j++) begin
      state_d[j] = state_q[j];
      case (state_q[j])
        ST_IDLE: begin
          if (|gnt[j]) begin
            state_d[j] = ST_LOCKED;
            owner_d[j] = gnt_idx[j];
          end
        end
        ST_LOCKED: begin
          out_busy[j]            = 1'b1;
          sel_w[j]               = owner_q[j];
          out_valid[j]           = in_valid[owner_q[j]];
          ready_lk[owner_q[j]]   = out_ready[j];
          if (in_valid[owner_q[j]] && out_ready[j] && in_tail[owner_q[j]]) begin
            state_d[j] = ST_IDLE;
            rr_d[j]    = (int'(owner_q[j]) == NPORTS - 1) ? '0 : owner_q[j] + 1'b1;
          end
        end
        default: state_d[j] = ST_IDLE;
      endcase
    end
  end

  // Drop flag: set on an unroutable head, cleared when its tail is taken.
  always_comb begin
    drop_d = drop_q;
    for (int i = 0; i < NPORTS; i++) begin
      if (drop_head[i]) begin
        drop_d[i] = ~in_tail[i];
      end else if (drop_q[i] && in_valid[i] && in_tail[i]) begin
        drop_d[i] = 1'b0;
      end
    end
  end

  // State, owner, pointer and drop registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NPORTS; j++) begin
        state_q[j] <= ST_IDLE;
      end
      owner_q <= '0;
      rr_q    <= '0;
      drop_q  <= '0;
    end else begin
      for (int j = 0; j < NPORTS; j++) begin
        state_q[j] <= state_d[j];
      end
      owner_q <= owner_d;
      rr_q    <= rr_d;
      drop_q  <= drop_d;
    end
  end

  assign out_sel  = sel_w;
  assign in_ready = ready_lk | drop_head | drop_q;
  assign drop_err = drop_head;

endmodule
